cs_host_sequencer: RTL and testbench
====================================

// Module: cs_host_sequencer
// PURPOSE
//  Initiator side of the computation-storage (CS) port. Buffers host commands
//  {op, addA, addB, addC, data} in a small FIFO and issues them one at a time to
//  the CS unit. Waits for seq_finished, captures DQ_out and returns it on a
//  valid/ready response channel. Sits between the host/testbench and the CS unit.
// PARAMETERS
//  MEM_WIDTH      8   data width (DQ_in/DQ_out/rsp_data)
//  MEM_DEPTH      16  CS memory depth; AW = $clog2(MEM_DEPTH)
//  NO_OPERATIONS  4   op count; OW = $clog2(NO_OPERATIONS)
//  CMD_DEPTH      4   command FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES 64  WAIT-state limit (used only with CS_TIMEOUT_EN)
// PORTS
//  clk              in   1          clock, rising edge
//  rst              in   1          async reset, active-high
//  cmd_valid        in   1          host command valid
//  cmd_ready        out  1          FIFO can accept (= !full, 0 while rst)
//  cmd_op           in   OW         operation select
//  cmd_addA/B/C     in   AW each    operand A/B and destination addresses
//  cmd_data         in   MEM_WIDTH  write data driven on DQ_in
//  rsp_valid        out  1          response valid
//  rsp_ready        in   1          host accepts response
//  rsp_data         out  MEM_WIDTH  captured DQ_out
//  rsp_err          out  1          response is a timeout
//  busy             out  1          state != IDLE or FIFO non-empty
//  cs_start         out  1          one-cycle issue strobe to CS unit
//  addA/addB/addC   out  AW each    registered addresses to CS unit
//  operation_select out  OW         registered op to CS unit
//  DQ_in            out  MEM_WIDTH  registered write data to CS unit
//  DQ_out           in   MEM_WIDTH  CS result
//  seq_finished     in   1          CS done pulse, DQ_out valid same cycle
// BEHAVIOUR
//  Reset: FIFO emptied, state IDLE; cs_start, rsp_valid, rsp_err, busy = 0;
//   addA/B/C, operation_select, DQ_in, rsp_data = 0. Applies mid-operation too:
//   in-flight and queued commands are dropped, no response is produced.
//  FIFO: push on cmd_valid&&cmd_ready. Full => cmd_ready=0, even when popping
//   in the same cycle (no bypass). Pointers wrap modulo CMD_DEPTH.
//  FSM IDLE: FIFO non-empty -> pop, load CS output regs, go ISSUE.
//  ISSUE (1 cycle): cs_start=1 -> WAIT. Min 2 cycles from push edge to cs_start.
//  WAIT: CS outputs held stable. seq_finished=1 -> rsp_data<=DQ_out, rsp_err<=0,
//   go RESP. seq_finished is ignored outside WAIT.
//  RESP: rsp_valid=1 and rsp_data/rsp_err held until rsp_ready. Handshake ->
//   rsp_valid=0, go IDLE. Next cs_start follows 2 cycles after the handshake.
//  One command is outstanding at a time. Responses are returned in command order.
// CONFIGURATION
//  CS_TIMEOUT_EN defined: WAIT counts cycles from 0. If seq_finished is not seen
//   after TIMEOUT_CYCLES cycles -> RESP with rsp_data=0, rsp_err=1. seq_finished
//   on the expiry cycle wins: normal response, rsp_err=0.
//  Not defined: no counter; WAIT is held indefinitely; rsp_err tied to 0.
// TESTING
//  1 Reset mid-WAIT: rst pulse -> all outputs 0, cmd_ready=1 after release,
//    late seq_finished gives no response.
//  2 Single cmd op=2,A=3,B=5,C=7,data=8'hA5 -> cs_start 2 cycles later with
//    addA=3,addB=5,addC=7,operation_select=2,DQ_in=A5; seq_finished with
//    DQ_out=8'h3C -> rsp_valid next cycle, rsp_data=3C, rsp_err=0.
//  3 Push 5 cmds back-to-back, CS stalled -> cmd_ready=0 after 4th accept;
//    5 responses in order once CS responds.
//  4 Hold rsp_ready=0 for 10 cycles -> rsp_data stable, no new cs_start until
//    the handshake.
//  5 CS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no seq_finished -> rsp_err=1, rsp_data=0;
//    a following command then completes normally.
//  6 Spurious seq_finished in IDLE/RESP -> ignored, no extra response.

Source files
------------

// File: rtl/cs_host_sequencer.sv
// Host-side sequencer for the CS port: queues commands and runs them one at a time.
// Optional WAIT-state watchdog is enabled by defining CS_TIMEOUT_EN.
module cs_host_sequencer #(
  parameter int MEM_WIDTH      = 8,
  parameter int MEM_DEPTH      = 16,
  parameter int NO_OPERATIONS  = 4,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int OW = $clog2(NO_OPERATIONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OW-1:0]        cmd_op,
  input  logic [AW-1:0]        cmd_addA,
  input  logic [AW-1:0]        cmd_addB,
  input  logic [AW-1:0]        cmd_addC,
  input  logic [MEM_WIDTH-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 cs_start,
  output logic [AW-1:0]        addA,
  output logic [AW-1:0]        addB,
  output logic [AW-1:0]        addC,
  output logic [OW-1:0]        operation_select,
  output logic [MEM_WIDTH-1:0] DQ_in,
  input  logic [MEM_WIDTH-1:0] DQ_out,
  input  logic                 seq_finished
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = OW + 3 * AW + MEM_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state;
  logic [CW-1:0]  fifo_mem [CMD_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  logic [OW-1:0]        head_op;
  logic [AW-1:0]        head_a;
  logic [AW-1:0]        head_b;
  logic [AW-1:0]        head_c;
  logic [MEM_WIDTH-1:0] head_data;

  assign full      = (count == (PW + 1)'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign busy      = (state != S_IDLE) || !empty;

  assign {head_op, head_a, head_b, head_c, head_data} = fifo_mem[rd_ptr];

  // Storage has no reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_op, cmd_addA, cmd_addB, cmd_addC, cmd_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          rsp_err_q;

  assign rsp_err = rsp_err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign rsp_err = 1'b0;
`endif

  // cs_start is raised on leaving ISSUE so it lands two edges after the push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cs_start         <= 1'b0;
      addA             <= '0;
      addB             <= '0;
      addC             <= '0;
      operation_select <= '0;
      DQ_in            <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
`ifdef CS_TIMEOUT_EN
      wait_cnt         <= '0;
      rsp_err_q        <= 1'b0;
`endif
    end else begin
      cs_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            addA             <= head_a;
            addB             <= head_b;
            addC             <= head_c;
            operation_select <= head_op;
            DQ_in            <= head_data;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cs_start <= 1'b1;
`ifdef CS_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (seq_finished) begin
            rsp_data  <= DQ_out;
            rsp_valid <= 1'b1;
`ifdef CS_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
            state     <= S_RESP;
          end
`ifdef CS_TIMEOUT_EN
          // A completion on the final allowed cycle still counts as a normal finish.
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            rsp_err_q <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_host_sequencer.sv
// Directed self-checking bench for cs_host_sequencer; the CS unit is played by hand.
// Timeout scenarios run only when CS_TIMEOUT_EN is defined.
module tb_cs_host_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_addA = '0;
  logic [3:0] cmd_addB = '0;
  logic [3:0] cmd_addC = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       cs_start;
  logic [3:0] addA;
  logic [3:0] addB;
  logic [3:0] addC;
  logic [1:0] operation_select;
  logic [7:0] DQ_in;
  logic [7:0] DQ_out = '0;
  logic       seq_finished = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  cs_host_sequencer #(
    .MEM_WIDTH(8), .MEM_DEPTH(16), .NO_OPERATIONS(4), .CMD_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addA(cmd_addA), .cmd_addB(cmd_addB), .cmd_addC(cmd_addC), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .cs_start(cs_start), .addA(addA), .addB(addB), .addC(addC),
    .operation_select(operation_select), .DQ_in(DQ_in), .DQ_out(DQ_out),
    .seq_finished(seq_finished)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge while cmd_ready is known to be high; the next edge accepts.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addA  = a;
    cmd_addB  = b;
    cmd_addC  = c;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitStart(input string tag);
    int n = 0;
    while (cs_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, cs_start, 1);
  endtask

  task automatic serve(input string tag, input logic [3:0] exp_a, input logic [7:0] exp_d,
                       input logic [7:0] dq, input int hold);
    waitStart({tag, " start"});
    checkOutput({tag, " addA"}, addA, exp_a);
    checkOutput({tag, " DQ_in"}, DQ_in, exp_d);
    tick();
    seq_finished = 1'b1;
    DQ_out       = dq;
    tick();
    seq_finished = 1'b0;
    DQ_out       = '0;
    checkOutput({tag, " rsp_valid"}, rsp_valid, 1);
    checkOutput({tag, " rsp_data"}, rsp_data, dq);
    checkOutput({tag, " rsp_err"}, rsp_err, 0);
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        seq_finished = 1'b1;
        DQ_out       = 8'hEE;
      end else begin
        seq_finished = 1'b0;
        DQ_out       = '0;
      end
      tick();
      checkOutput({tag, " hold valid"}, rsp_valid, 1);
      checkOutput({tag, " hold data"}, rsp_data, dq);
      checkOutput({tag, " hold no start"}, cs_start, 0);
    end
    seq_finished = 1'b0;
    rsp_ready    = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, " rsp drop"}, rsp_valid, 0);
  endtask

  initial begin
    // Reset values while rst is held
    tick();
    tick();
    checkOutput("rst cmd_ready", cmd_ready, 0);
    checkOutput("rst cs_start", cs_start, 0);
    checkOutput("rst rsp_valid", rsp_valid, 0);
    checkOutput("rst rsp_err", rsp_err, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst addA", addA, 0);
    checkOutput("rst addB", addB, 0);
    checkOutput("rst addC", addC, 0);
    checkOutput("rst op", operation_select, 0);
    checkOutput("rst DQ_in", DQ_in, 0);
    checkOutput("rst rsp_data", rsp_data, 0);
    rst = 1'b0;
    tick();
    checkOutput("release cmd_ready", cmd_ready, 1);

    // Reset in the middle of WAIT with a second command still queued
    applyStimulus(2'd1, 4'd1, 4'd2, 4'd3, 8'h11);
    applyStimulus(2'd3, 4'd4, 4'd5, 4'd6, 8'h22);
    waitStart("midrst start");
    rst = 1'b1;
    #1;
    checkOutput("midrst cs_start", cs_start, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst cmd_ready", cmd_ready, 0);
    checkOutput("midrst addA", addA, 0);
    checkOutput("midrst op", operation_select, 0);
    checkOutput("midrst DQ_in", DQ_in, 0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("midrst release ready", cmd_ready, 1);
    seq_finished = 1'b1;
    DQ_out       = 8'hFF;
    tick();
    seq_finished = 1'b0;
    DQ_out       = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("late fin no rsp", rsp_valid, 0);
      checkOutput("dropped queue idle", busy, 0);
    end

    // Single command with exact issue latency
    applyStimulus(2'd2, 4'd3, 4'd5, 4'd7, 8'hA5);
    checkOutput("single lat1", cs_start, 0);
    tick();
    checkOutput("single lat2", cs_start, 0);
    checkOutput("single busy", busy, 1);
    tick();
    checkOutput("single start", cs_start, 1);
    checkOutput("single addA", addA, 3);
    checkOutput("single addB", addB, 5);
    checkOutput("single addC", addC, 7);
    checkOutput("single op", operation_select, 2);
    checkOutput("single DQ_in", DQ_in, 8'hA5);
    tick();
    checkOutput("single strobe end", cs_start, 0);
    seq_finished = 1'b1;
    DQ_out       = 8'h3C;
    tick();
    seq_finished = 1'b0;
    DQ_out       = '0;
    checkOutput("single rsp_valid", rsp_valid, 1);
    checkOutput("single rsp_data", rsp_data, 8'h3C);
    checkOutput("single rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("single rsp drop", rsp_valid, 0);
    checkOutput("single idle", busy, 0);

    // Stalled CS: one command in flight, then fill the FIFO
    applyStimulus(2'd0, 4'd9, 4'd0, 4'd0, 8'h99);
    waitStart("fill x start");
    for (int k = 0; k < 4; k++) begin
      checkOutput("fill ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = k[1:0];
      cmd_addA  = k[3:0];
      cmd_addB  = 4'(k + 1);
      cmd_addC  = 4'(k + 2);
      cmd_data  = 8'h10 + 8'(k);
      tick();
    end
    checkOutput("fill full", cmd_ready, 0);
    cmd_op   = 2'd0;
    cmd_addA = 4'd4;
    cmd_addB = 4'd5;
    cmd_addC = 4'd6;
    cmd_data = 8'h14;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("fill stall ready", cmd_ready, 0);
      checkOutput("fill stall busy", busy, 1);
    end
    seq_finished = 1'b1;
    DQ_out       = 8'h90;
    tick();
    seq_finished = 1'b0;
    DQ_out       = '0;
    checkOutput("x rsp_valid", rsp_valid, 1);
    checkOutput("x rsp_data", rsp_data, 8'h90);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("x rsp drop", rsp_valid, 0);
    checkOutput("x still full", cmd_ready, 0);
    tick();
    checkOutput("pop frees slot", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    checkOutput("c0 start on time", cs_start, 1);
    checkOutput("refilled full", cmd_ready, 0);
    serve("c0", 4'd0, 8'h10, 8'h40, 0);
    serve("c1", 4'd1, 8'h11, 8'h41, 10);
    serve("c2", 4'd2, 8'h12, 8'h42, 0);
    serve("c3", 4'd3, 8'h13, 8'h43, 0);
    serve("c4", 4'd4, 8'h14, 8'h44, 0);
    tick();
    checkOutput("drained idle", busy, 0);

    // Spurious completion while idle
    seq_finished = 1'b1;
    DQ_out       = 8'h77;
    tick();
    seq_finished = 1'b0;
    DQ_out       = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle spurious no rsp", rsp_valid, 0);
      checkOutput("idle spurious no start", cs_start, 0);
    end

`ifdef CS_TIMEOUT_EN
    // WAIT expires after 8 cycles with no completion
    applyStimulus(2'd1, 4'd8, 4'd9, 4'd10, 8'h55);
    waitStart("to start");
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("to pending", rsp_valid, 0);
    end
    tick();
    checkOutput("to rsp_valid", rsp_valid, 1);
    checkOutput("to rsp_err", rsp_err, 1);
    checkOutput("to rsp_data", rsp_data, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("to rsp drop", rsp_valid, 0);

    // Completion on the expiry cycle is a normal response
    applyStimulus(2'd2, 4'd11, 4'd12, 4'd13, 8'h66);
    waitStart("edge start");
    for (int i = 0; i < 7; i++) tick();
    seq_finished = 1'b1;
    DQ_out       = 8'h5A;
    tick();
    seq_finished = 1'b0;
    DQ_out       = '0;
    checkOutput("edge rsp_valid", rsp_valid, 1);
    checkOutput("edge rsp_err", rsp_err, 0);
    checkOutput("edge rsp_data", rsp_data, 8'h5A);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    applyStimulus(2'd3, 4'd14, 4'd15, 4'd1, 8'h67);
    serve("after to", 4'd14, 8'h67, 8'hC3, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
